renkon_ctrl_linebuf: RTL and testbench
======================================

# renkon_ctrl_linebuf

Control unit for the line buffer in front of the renkon convolution core. It counts incoming pixels of a square feature map and steers writes into a ring of up to FSIZE line memories. It tells the window datapath when a full fil_size×fil_size window is available and which line holds the oldest row. It holds only control state; the line memories and window shift registers live in the datapath next to it.

## Interface
- FSIZE, 5: maximum kernel side, equal to the number of line memories.
- MAXWIDTH, 256: maximum image side, equal to the depth of each line memory.
- LWIDTH, 9: width of the size inputs; must be at least $clog2(MAXWIDTH+1).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  start pulse; sampled only in IDLE.
- img_size  in  LWIDTH  image side N, legal range 1..MAXWIDTH; latched on req.
- fil_size  in  4  kernel side F; latched on req. 0 is treated as 1; values above FSIZE are clamped to FSIZE.
- in_valid  in  1  one pixel is presented to the line buffer this cycle; ignored outside RUN.
- ack  out  1  high in IDLE (ready for req).
- buf_we  out  FSIZE  one-hot write enable for the line memories; equals in_valid gated onto the current line `wsel`.
- buf_addr  out  $clog2(MAXWIDTH)  write and read address, equal to the current column.
- out_valid  out  1  a complete window is available; registered.
- out_rsel  out  $clog2(FSIZE)  index of the line memory holding the top (oldest) window row; valid with out_valid.
- out_last  out  1  last window of the image; coincides with out_valid.
- done  out  1  one-cycle pulse when the image has been fully consumed.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on req. On that transition: latch N and the clamped F; set row=0, col=0, wsel=0.
  - RUN → DONE on the in_valid that carries the pixel at row=N-1, col=N-1.
  - DONE → IDLE unconditionally after one cycle.
- Behaviour of each in_valid in RUN:
  - Assert buf_we[wsel] combinationally, with buf_addr=col.
  - If col==N-1: set col=0, row=row+1, and wsel=(wsel+1) mod F.
  - Otherwise: col=col+1.
- Window condition, evaluated on the pre-increment row and col: row≥F-1 and col≥F-1.
  - When met, out_valid pulses on the next cycle.
  - out_rsel = (wsel+1) mod F, taken from the pre-increment wsel. For F=1, out_rsel=0.
  - out_last is asserted together with out_valid when row=N-1 and col=N-1.
- If F>N, no window is ever produced; out_valid and out_last stay 0, and done still pulses.
- req while not in IDLE is ignored. A new image never aborts the current one.
- Arithmetic: all counters are unsigned. row and col each have $clog2(MAXWIDTH) bits. No wrap can occur beyond N-1.

## Timing
- Reset values: state=IDLE, ack=1, and every other output 0. Reset clears the counters and the latched sizes. Reset mid-image returns to IDLE immediately and drops any pending out_valid.
- req→RUN: 1 cycle. ack falls in the cycle after req is sampled.
- buf_we and buf_addr: 0 cycles after in_valid (combinational from registered counters).
- out_valid, out_rsel, out_last: 1 cycle after the qualifying in_valid.
- done is high in the DONE state, i.e. 1 cycle after the final in_valid, in the same cycle as the final out_valid. ack returns high the cycle after done.
- Back-to-back in_valid at full rate is supported; gaps of any length are allowed.

## Structure
- The shared renkon package holds FSIZE, MAXWIDTH, LWIDTH, and the state enum (IDLE, RUN, DONE).
- The block is a single module with no sub-modules. An optional helper, renkon_ring_counter (the mod-F counter for wsel), may be factored out.

## Test plan
- Reset: assert rst mid-RUN → next cycle ack=1; out_valid, done, and buf_we are all 0; a new req starts again from row=0, col=0.
- N=4, F=3, continuous in_valid for 16 cycles:
  - exactly 4 out_valid pulses, after pixels 10, 11, 14, and 15;
  - out_rsel=0,0,1,1;
  - out_last only on the 4th pulse;
  - done 1 cycle after pixel 15.
- N=4, F=3: check buf_we rotates line0, line1, line2, line0 on row changes, and buf_addr cycles 0..3.
- N=3, F=1: 9 windows, one per pixel, each 1 cycle later; out_rsel=0 throughout.
- N=2, F=3: no out_valid; done after 4 pixels. Also check fil_size=7 clamps to 5, and fil_size=0 behaves as 1.
- Random in_valid gaps, plus a req during RUN: window count is unchanged, and the second req is ignored.

Source files
------------

// File: rtl/renkon_ctrl_linebuf_pkg.sv
// Shared constants, FSM state type and kernel-size clamp
// for the renkon line-buffer controller.
package renkon_ctrl_linebuf_pkg;

  localparam int FSIZE    = 5;
  localparam int MAXWIDTH = 256;
  localparam int LWIDTH   = 9;
  localparam int AW       = $clog2(MAXWIDTH);
  localparam int SW       = $clog2(FSIZE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // A kernel side of 0 means 1; anything above the line count saturates.
  function automatic logic [SW-1:0] clampFil(input logic [3:0] f);
    if (f == 4'd0) return SW'(1);
    if (f > 4'(FSIZE)) return SW'(FSIZE);
    return f[SW-1:0];
  endfunction

endpackage

// File: rtl/renkon_ctrl_linebuf_ring.sv
// Modulo-M ring counter selecting the line memory currently being written.
// nxt_o is the successor value, also used for the oldest-row index.
module renkon_ring_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         adv_i,
  input  logic [W-1:0] mod_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] nxt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] inc;

  assign inc   = cnt_q + W'(1);
  assign nxt_o = (inc >= mod_i) ? '0 : inc;
  assign cnt_o = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (adv_i) begin
      cnt_q <= nxt_o;
    end
  end

endmodule

// File: rtl/renkon_ctrl_linebuf.sv
// Line-buffer controller: counts pixels of an NxN image, steers writes into
// a ring of line memories and flags when a full FxF window is available.
module renkon_ctrl_linebuf
  import renkon_ctrl_linebuf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [LWIDTH-1:0] img_size_i,
  input  logic [3:0]        fil_size_i,
  input  logic              in_valid_i,
  output logic              ack_o,
  output logic [FSIZE-1:0]  buf_we_o,
  output logic [AW-1:0]     buf_addr_o,
  output logic              out_valid_o,
  output logic [SW-1:0]     out_rsel_o,
  output logic              out_last_o,
  output logic              done_o
);

  state_e            state_q, state_d;
  logic [LWIDTH-1:0] n_q, n_d;
  logic [SW-1:0]     f_q, f_d;
  logic [AW-1:0]     row_q, row_d, col_q, col_d;
  logic              valid_q, valid_d, last_q, last_d;
  logic [SW-1:0]     rsel_q, rsel_d;

  logic              start, take, colEnd, rowEnd, win;
  logic [LWIDTH-1:0] nm1;
  logic [AW-1:0]     fm1;
  logic [SW-1:0]     wsel, wselNxt;

  assign take   = (state_q == RUN) && in_valid_i;
  assign nm1    = n_q - LWIDTH'(1);
  assign fm1    = AW'(f_q) - AW'(1);
  assign colEnd = (LWIDTH'(col_q) == nm1);
  assign rowEnd = (LWIDTH'(row_q) == nm1);
  assign win    = (row_q >= fm1) && (col_q >= fm1);

  renkon_ring_counter #(.W(SW)) u_wsel (
    .clk     (clk),
    .rst     (rst),
    .clear_i (start),
    .adv_i   (take && colEnd),
    .mod_i   (f_q),
    .cnt_o   (wsel),
    .nxt_o   (wselNxt)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    f_d     = f_q;
    row_d   = row_q;
    col_d   = col_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    rsel_d  = rsel_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          state_d = RUN;
          n_d     = img_size_i;
          f_d     = clampFil(fil_size_i);
          row_d   = '0;
          col_d   = '0;
          start   = 1'b1;
        end
      end
      RUN: begin
        if (in_valid_i) begin
          // Window decision uses the counters before this pixel advances them.
          valid_d = win;
          last_d  = win && colEnd && rowEnd;
          rsel_d  = wselNxt;
          if (colEnd) begin
            col_d = '0;
            row_d = row_q + AW'(1);
            if (rowEnd) state_d = DONE;
          end else begin
            col_d = col_q + AW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      f_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      rsel_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      f_q     <= f_d;
      row_q   <= row_d;
      col_q   <= col_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      rsel_q  <= rsel_d;
    end
  end

  assign ack_o       = (state_q == IDLE);
  assign done_o      = (state_q == DONE);
  assign buf_we_o    = take ? (FSIZE'(1) << wsel) : '0;
  assign buf_addr_o  = col_q;
  assign out_valid_o = valid_q;
  assign out_last_o  = last_q;
  assign out_rsel_o  = rsel_q;

endmodule

// File: tb/tb_renkon_ctrl_linebuf.sv
// Self-checking bench for renkon_ctrl_linebuf: directed and randomized images
// compared against a pixel-index reference model.
module tb_renkon_ctrl_linebuf;
  import renkon_ctrl_linebuf_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              req;
  logic [LWIDTH-1:0] img_size;
  logic [3:0]        fil_size;
  logic              in_valid;
  logic              ack;
  logic [FSIZE-1:0]  buf_we;
  logic [AW-1:0]     buf_addr;
  logic              out_valid;
  logic [SW-1:0]     out_rsel;
  logic              out_last;
  logic              done;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 running, 2 done; pixels consumed so far.
  int mState = 0;
  int mN = 1;
  int mF = 1;
  int mPix = 0;
  int obsWin = 0;
  int pulsePix[$];
  int pulseRsel[$];

  renkon_ctrl_linebuf dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .img_size_i  (img_size),
    .fil_size_i  (fil_size),
    .in_valid_i  (in_valid),
    .ack_o       (ack),
    .buf_we_o    (buf_we),
    .buf_addr_o  (buf_addr),
    .out_valid_o (out_valid),
    .out_rsel_o  (out_rsel),
    .out_last_o  (out_last),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  function automatic int clampRef(input int f);
    if (f == 0) return 1;
    if (f > FSIZE) return FSIZE;
    return f;
  endfunction

  function automatic int expWindows(input int n, input int f);
    int fe;
    fe = clampRef(f);
    if (fe > n) return 0;
    return (n - fe + 1) * (n - fe + 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts at posedge+1: drive, check combinational outputs, clock, check registered outputs.
  task automatic applyStimulus(input logic v, input logic r, input int n, input int f);
    int row, col, nState, nR;
    logic nV, nL, nD;
    in_valid = v;
    req      = r;
    img_size = LWIDTH'(n);
    fil_size = 4'(f);
    #1;
    checkOutput("ack", 32'(ack), 32'(mState == 0));
    nV = 1'b0; nL = 1'b0; nD = 1'b0; nR = 0;
    nState = mState;
    if (mState == 1 && v) begin
      row = mPix / mN;
      col = mPix % mN;
      checkOutput("buf_we", 32'(buf_we), 32'(1) << (row % mF));
      checkOutput("buf_addr", 32'(buf_addr), 32'(col));
      nV = (row >= mF - 1) && (col >= mF - 1);
      nR = (row + 1) % mF;
      nD = (mPix == mN * mN - 1);
      nL = nV && nD;
      mPix++;
      if (nD) nState = 2;
    end else begin
      checkOutput("buf_we_quiet", 32'(buf_we), 32'd0);
      if (mState == 0 && r) begin
        nState = 1;
        mN = n;
        mF = clampRef(f);
        mPix = 0;
      end else if (mState == 2) begin
        nState = 0;
      end
    end
    mState = nState;
    @(posedge clk);
    #1;
    checkOutput("out_valid", 32'(out_valid), 32'(nV));
    checkOutput("out_last", 32'(out_last), 32'(nL));
    checkOutput("done", 32'(done), 32'(nD));
    if (nV) checkOutput("out_rsel", 32'(out_rsel), 32'(nR));
    if (out_valid) begin
      obsWin++;
      pulsePix.push_back(mPix - 1);
      pulseRsel.push_back(int'(out_rsel));
    end
  endtask

  task automatic runImage(input int n, input int f, input int gapPct, input bit injectReq);
    int cyc;
    logic v, r;
    obsWin = 0;
    pulsePix.delete();
    pulseRsel.delete();
    applyStimulus(1'b0, 1'b1, n, f);
    cyc = 0;
    while (mState != 0 && cyc < 20000) begin
      v = ($urandom_range(0, 99) >= gapPct);
      r = injectReq && ($urandom_range(0, 7) == 0);
      if (r) applyStimulus(v, r, $urandom_range(1, 8), $urandom_range(0, 7));
      else   applyStimulus(v, r, n, f);
      cyc++;
    end
    in_valid = 1'b0;
    req = 1'b0;
    checkOutput("win_count", 32'(obsWin), 32'(expWindows(n, f)));
  endtask

  initial begin
    int n, f;
    int expPix[4];
    int expRs[4];
    rst = 1'b1; req = 1'b0; in_valid = 1'b0; img_size = '0; fil_size = '0;
    #12;
    checkOutput("rst_ack", 32'(ack), 32'd1);
    checkOutput("rst_buf_we", 32'(buf_we), 32'd0);
    checkOutput("rst_buf_addr", 32'(buf_addr), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_rsel", 32'(out_rsel), 32'd0);
    checkOutput("rst_out_last", 32'(out_last), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] N=4 F=3 continuous");
    runImage(4, 3, 0, 1'b0);
    expPix = '{10, 11, 14, 15};
    expRs  = '{0, 0, 1, 1};
    checkOutput("n4f3_pulses", 32'(pulsePix.size()), 32'd4);
    for (int i = 0; i < 4 && i < pulsePix.size(); i++) begin
      checkOutput("n4f3_pulse_pix", 32'(pulsePix[i]), 32'(expPix[i]));
      checkOutput("n4f3_pulse_rsel", 32'(pulseRsel[i]), 32'(expRs[i]));
    end

    $display("[TB] N=3 F=1, N=2 F=3, clamp cases, N=1");
    runImage(3, 1, 0, 1'b0);
    runImage(2, 3, 0, 1'b0);
    runImage(6, 7, 0, 1'b0);
    runImage(3, 0, 0, 1'b0);
    runImage(1, 1, 0, 1'b0);

    $display("[TB] gaps with req during RUN");
    runImage(5, 3, 40, 1'b1);

    $display("[TB] reset mid-image");
    applyStimulus(1'b0, 1'b1, 4, 2);
    repeat (6) applyStimulus(1'b1, 1'b0, 4, 2);
    in_valid = 1'b1;
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_ack", 32'(ack), 32'd1);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_buf_we", 32'(buf_we), 32'd0);
    mState = 0;
    in_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    runImage(4, 2, 0, 1'b0);

    $display("[TB] randomized images");
    repeat (8) begin
      n = $urandom_range(1, 9);
      f = $urandom_range(0, 7);
      runImage(n, f, 30, 1'b1);
    end
    runImage(40, 5, 20, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
